// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Hits are answered combinationally. A miss stalls the pipeline while a
// write-back of a dirty victim and/or a line refill runs against memory.
// Ports:
//   clk_i, start_i (async active-low reset)
//   cpu_req_i/cpu_we_i/cpu_addr_i/cpu_wdata_i : CPU access (held stable while stalled)
//   cpu_rdata_o, cpu_stall_o                  : hit data, pipeline freeze
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : line request to memory
//   mem_rdata_i, mem_ack_i                    : refill data, completion pulse
module dcache_controller #(
    parameter int unsigned LINES  = 16,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned WORD_W = OFF_W - 2;
    localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] ZERO_OFF = '0;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t              state;
    logic [LINES-1:0]    validQ;
    logic [LINES-1:0]    dirtyQ;
    logic [TAG_W-1:0]    tagMem  [LINES];
    logic [LINE_W-1:0]   dataMem [LINES];

    logic                memReq;
    logic                memWe;
    logic [31:0]         memAddr;
    logic [LINE_W-1:0]   memWdata;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    reqTag;
    logic [WORD_W-1:0]   wordSel;
    logic [WORD_W+4:0]   bitSel;
    logic [LINE_W-1:0]   selLine;
    logic                hit;
    logic [1:0]          unusedAddr;

    // Address decode: tag | index | word | byte
    assign idx        = cpu_addr_i[OFF_W +: IDX_W];
    assign reqTag     = cpu_addr_i[31 -: TAG_W];
    assign wordSel    = cpu_addr_i[2 +: WORD_W];
    assign bitSel     = {wordSel, 5'b0};
    assign unusedAddr = cpu_addr_i[1:0];

    assign selLine = dataMem[idx];
    assign hit     = cpu_req_i & validQ[idx] & (tagMem[idx] == reqTag);

    // Combinational CPU side: the pipeline needs hit data and stall in-cycle
    assign cpu_stall_o = (state == IDLE) ? (cpu_req_i & ~hit) : 1'b1;
    assign cpu_rdata_o = hit ? selLine[bitSel +: 32] : 32'h0;

    assign mem_req_o   = memReq;
    assign mem_we_o    = memWe;
    assign mem_addr_o  = memAddr;
    assign mem_wdata_o = memWdata;

    // Controller FSM; memory-side outputs are registered alongside the state
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state    <= IDLE;
            validQ   <= '0;
            dirtyQ   <= '0;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req_i && !hit) begin
                        memReq <= 1'b1;
                        if (validQ[idx] && dirtyQ[idx]) begin
                            state    <= WRITEBACK;
                            memWe    <= 1'b1;
                            memAddr  <= {tagMem[idx], idx, ZERO_OFF};
                            memWdata <= selLine;
                        end else begin
                            state    <= ALLOCATE;
                            memWe    <= 1'b0;
                            memAddr  <= {reqTag, idx, ZERO_OFF};
                            memWdata <= '0;
                        end
                    end else if (hit && cpu_we_i) begin
                        dirtyQ[idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    // Request stays up across the boundary; only direction and address change
                    if (mem_ack_i) begin
                        state    <= ALLOCATE;
                        memWe    <= 1'b0;
                        memAddr  <= {reqTag, idx, ZERO_OFF};
                        memWdata <= '0;
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state       <= IDLE;
                        memReq      <= 1'b0;
                        memAddr     <= '0;
                        validQ[idx] <= 1'b1;
                        dirtyQ[idx] <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    memReq <= 1'b0;
                    memWe  <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity is tracked by validQ
    always_ff @(posedge clk_i) begin
        if (state == IDLE && hit && cpu_we_i) begin
            dataMem[idx][bitSel +: 32] <= cpu_wdata_i;
        end else if (state == ALLOCATE && mem_ack_i) begin
            dataMem[idx] <= mem_rdata_i;
            tagMem[idx]  <= reqTag;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a vector table of CPU accesses with
// hand-computed stall lengths, memory transactions and load data, driven
// against a small line-memory model, plus a reset-during-refill sequence.
module tb_dcache_controller;
    logic         clk_i = 1'b0;
    logic         start_i;
    logic         cpuReq, cpuWe;
    logic [31:0]  cpuAddr, cpuWdata;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o, mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] memRdata;
    logic         memAck;

    int checks = 0;
    int errors = 0;

    logic [255:0] backing [logic [31:0]];

    dcache_controller dut (
        .clk_i       (clk_i),
        .start_i     (start_i),
        .cpu_req_i   (cpuReq),
        .cpu_we_i    (cpuWe),
        .cpu_addr_i  (cpuAddr),
        .cpu_wdata_i (cpuWdata),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (memRdata),
        .mem_ack_i   (memAck)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          expStall;
        logic [31:0] expRdata;
        logic        expWb;
        logic [31:0] expWbAddr;
        int          wbWordIdx;
        logic [31:0] expWbWord;
        logic [31:0] expFetch;
    } acc_t;

    acc_t tbl [12];

    // Default memory content: word w of line a = C0DE_0000 | a[15:0] | w
    function automatic logic [255:0] patLine(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hC0DE_0000 | {16'h0, a[15:0]} | 32'(w);
        return l;
    endfunction

    function automatic logic [255:0] lineOf(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return patLine(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one access from a negedge and run the memory model until the stall clears
    task automatic runAccess(input int n, input acc_t r);
        int          stallCyc = 0;
        int          reqCyc = 0;
        int          phaseCyc = 0;
        bit          done = 0;
        bit          sawWb = 0;
        bit          sawFetch = 0;
        logic [31:0] wbAddr = '0;
        logic [31:0] wbWord = '0;
        logic [31:0] fetchAddr = '0;
        logic [31:0] rdata = '0;
        string       tag;
        tag = $sformatf("acc%0d", n);
        cpuReq = 1'b1; cpuWe = r.we; cpuAddr = r.addr; cpuWdata = r.wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            if (!cpu_stall_o) begin
                done  = 1;
                rdata = cpu_rdata_o;
            end else begin
                stallCyc++;
                if (mem_req_o) begin
                    reqCyc++;
                    if (phaseCyc == 0) begin
                        if (mem_we_o) begin
                            sawWb  = 1;
                            wbAddr = mem_addr_o;
                            wbWord = mem_wdata_o[r.wbWordIdx*32 +: 32];
                        end else begin
                            sawFetch  = 1;
                            fetchAddr = mem_addr_o;
                        end
                    end
                    phaseCyc++;
                    if (phaseCyc == r.lat) begin
                        memAck = 1'b1;
                        if (mem_we_o) backing[mem_addr_o] = mem_wdata_o;
                        else          memRdata = lineOf(mem_addr_o);
                        phaseCyc = 0;
                    end
                end
                @(negedge clk_i);
                memAck = 1'b0;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: stall still high after %0d cycles", tag, stallCyc);
        end else begin
            check({tag, " stall cycles"}, 32'(stallCyc), 32'(r.expStall));
            check({tag, " req cycles"}, 32'(reqCyc), 32'(r.expStall > 0 ? r.expStall - 1 : 0));
            check({tag, " writeback seen"}, 32'(sawWb), 32'(r.expWb));
            if (r.expWb) begin
                check({tag, " wb addr"}, wbAddr, r.expWbAddr);
                check({tag, " wb word"}, wbWord, r.expWbWord);
            end
            if (r.expStall > 0) begin
                check({tag, " fetch seen"}, 32'(sawFetch), 32'd1);
                check({tag, " fetch addr"}, fetchAddr, r.expFetch);
            end
            if (!r.we) check({tag, " rdata"}, rdata, r.expRdata);
        end
        @(negedge clk_i);
    endtask

    initial begin
        logic [255:0] l;
        int           ph;
        acc_t         post;

        l = patLine(32'h100);
        l[63:32] = 32'hDEAD_BEEF;
        backing[32'h100] = l;

        //          we    addr         wdata         lat st  rdata          wb    wbAddr       wi wbWord         fetch
        tbl[0]  = '{1'b0, 32'h0000_0104, 32'h0,         10, 11, 32'hDEAD_BEEF, 1'b0, 32'h0,       0, 32'h0,         32'h100};
        tbl[1]  = '{1'b1, 32'h0000_0104, 32'h1234_5678, 1,  0,  32'h0,         1'b0, 32'h0,       0, 32'h0,         32'h0};
        tbl[2]  = '{1'b0, 32'h0000_0104, 32'h0,         1,  0,  32'h1234_5678, 1'b0, 32'h0,       0, 32'h0,         32'h0};
        tbl[3]  = '{1'b0, 32'h0000_0304, 32'h0,         10, 21, 32'hC0DE_0301, 1'b1, 32'h100,     1, 32'h1234_5678, 32'h300};
        tbl[4]  = '{1'b0, 32'h0000_0104, 32'h0,         10, 11, 32'h1234_5678, 1'b0, 32'h0,       0, 32'h0,         32'h100};
        tbl[5]  = '{1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 3,  4,  32'h0,         1'b0, 32'h0,       0, 32'h0,         32'h000};
        tbl[6]  = '{1'b0, 32'h0000_0008, 32'h0,         1,  0,  32'hA5A5_A5A5, 1'b0, 32'h0,       0, 32'h0,         32'h0};
        tbl[7]  = '{1'b0, 32'h0000_0208, 32'h0,         2,  5,  32'hC0DE_0202, 1'b1, 32'h000,     2, 32'hA5A5_A5A5, 32'h200};
        tbl[8]  = '{1'b0, 32'h0000_0104, 32'h0,         1,  0,  32'h1234_5678, 1'b0, 32'h0,       0, 32'h0,         32'h0};
        tbl[9]  = '{1'b0, 32'h0000_0208, 32'h0,         1,  0,  32'hC0DE_0202, 1'b0, 32'h0,       0, 32'h0,         32'h0};
        tbl[10] = '{1'b0, 32'h0000_000C, 32'h0,         1,  2,  32'hC0DE_0003, 1'b0, 32'h0,       0, 32'h0,         32'h000};
        tbl[11] = '{1'b0, 32'h0000_0008, 32'h0,         1,  2,  32'hA5A5_A5A5, 1'b0, 32'h0,       0, 32'h0,         32'h000};

        start_i = 1'b0;
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h104; cpuWdata = '0;
        memAck = 1'b0; memRdata = '0;
        #12;
        check("reset stall", 32'(cpu_stall_o), 32'd1);
        check("reset rdata", cpu_rdata_o, 32'h0);
        check("reset mem_req", 32'(mem_req_o), 32'd0);
        check("reset mem_we", 32'(mem_we_o), 32'd0);
        check("reset mem_addr", mem_addr_o, 32'h0);
        check("reset mem_wdata nonzero", 32'(mem_wdata_o != '0), 32'd0);
        cpuReq = 1'b0;
        #1;
        check("reset idle stall", 32'(cpu_stall_o), 32'd0);
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);

        // Entry 11 hits index 0 again only after entry 10 refilled it; it is a hit there
        tbl[11].lat = 1; tbl[11].expStall = 0;
        for (int i = 0; i < 12; i++) runAccess(i, tbl[i]);

        // Reset in the 5th cycle of a refill, followed by a late ack
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h0000_0504;
        ph = 0;
        for (int c = 0; c < 50 && ph < 5; c++) begin
            @(negedge clk_i);
            if (mem_req_o) ph++;
        end
        check("rst refill reached", 32'(ph), 32'd5);
        #1 start_i = 1'b0;
        #1;
        check("rst mem_req async", 32'(mem_req_o), 32'd0);
        check("rst mem_addr async", mem_addr_o, 32'h0);
        check("rst stall", 32'(cpu_stall_o), 32'd1);
        cpuReq = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        memAck = 1'b1; memRdata = patLine(32'h500);
        @(negedge clk_i);
        memAck = 1'b0;
        #1;
        check("late ack mem_req", 32'(mem_req_o), 32'd0);
        check("late ack stall", 32'(cpu_stall_o), 32'd0);
        @(negedge clk_i);
        post = '{1'b0, 32'h0000_0104, 32'h0, 2, 3, 32'h1234_5678, 1'b0, 32'h0, 0, 32'h0, 32'h100};
        runAccess(12, post);
        post = '{1'b0, 32'h0000_0504, 32'h0, 1, 2, 32'hC0DE_0501, 1'b0, 32'h0, 0, 32'h0, 32'h500};
        runAccess(13, post);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate L1 data cache sitting in the MEM stage of the five-stage pipeline, between the CPU load/store path and the off-chip data memory. It answers CPU accesses combinationally on a hit. On a miss it raises `cpu_stall_o`, which freezes the pipeline registers through their stall/enable inputs. While the pipeline is frozen it runs a write-back/refill handshake with off-chip memory.

## Interface
- `LINES`, 16: number of cache lines; index width = log2(LINES) = 4
- `LINE_W`, 256: line width in bits (8 words); byte offset = addr[4:0]
- `clk_i`  in  1: clock, rising edge
- `start_i`  in  1: reset. Asynchronous, active-low. One clock; the reset is asynchronous and active-low.
- `cpu_req_i`  in  1: MEM-stage access valid (MemRead | MemWrite)
- `cpu_we_i`  in  1: 1 = store, 0 = load
- `cpu_addr_i`  in  32: byte address, word-aligned. tag = [31:9], index = [8:5], word = [4:2]
- `cpu_wdata_i`  in  32: store data
- `cpu_rdata_o`  out  32: load data; valid in the same cycle as a hit
- `cpu_stall_o`  out  1: freeze pipeline; high while the access is unresolved
- `mem_req_o`  out  1: request to off-chip memory
- `mem_we_o`  out  1: 1 = line write-back, 0 = line fetch
- `mem_addr_o`  out  32: line address, [4:0] = 0
- `mem_wdata_o`  out  256: victim line
- `mem_rdata_i`  in  256: refill line; valid only in the cycle `mem_ack_i` = 1
- `mem_ack_i`  in  1: single-cycle completion pulse from memory

## Operation
- Per-line storage:
  - `valid` bit and `dirty` bit; both are cleared by reset.
  - 23-bit tag and 256-bit data; not reset.
- Hit condition: `hit = cpu_req_i & valid[idx] & (tag[idx] == addr[31:9])`.
- `cpu_stall_o` = `cpu_req_i & ~hit` while in IDLE, and 1 in every other state.
- `cpu_rdata_o` = word `addr[4:2]` of line `idx` when `hit` is true, otherwise 32'h0.
- Write hit: at the clock edge, replace the selected word and set `dirty[idx]`.
- CPU rule: `cpu_req_i`, `cpu_we_i`, `cpu_addr_i` and `cpu_wdata_i` must stay stable while `cpu_stall_o` = 1. This is guaranteed by the pipeline freeze.
- FSM has three states: IDLE, WRITEBACK, ALLOCATE.
  - IDLE, request misses:
    - victim `valid & dirty` → go to WRITEBACK;
    - otherwise → go to ALLOCATE.
  - WRITEBACK:
    - outputs: `mem_req_o` = 1, `mem_we_o` = 1, `mem_addr_o` = {victim tag, idx, 5'b0}, `mem_wdata_o` = victim line;
    - on `mem_ack_i` → go to ALLOCATE.
  - ALLOCATE:
    - outputs: `mem_req_o` = 1, `mem_we_o` = 0, `mem_addr_o` = {addr[31:9], idx, 5'b0};
    - on `mem_ack_i`: load `mem_rdata_i` into the line, set the tag, set valid = 1 and dirty = 0, then → go to IDLE.
  - The next IDLE cycle re-looks up and hits. A store completes as a write hit in that cycle, so the line becomes dirty.
- Memory-side outputs are decoded from state. In IDLE: `mem_req_o` = 0, `mem_we_o` = 0, `mem_addr_o` = 0, `mem_wdata_o` = 0.
- `mem_ack_i` received in IDLE is ignored.
- `mem_req_o` stays high, with address and data stable, until the ack cycle inclusive.

## Timing
- Hit: zero added latency; stall stays 0; read data is available combinationally.
- Let L = number of cycles from `mem_req_o` rising to `mem_ack_i`, inclusive.
  - Clean or invalid miss: stall is high for 1 + L cycles.
  - Dirty miss: stall is high for 1 + 2L cycles.
- WRITEBACK → ALLOCATE: `mem_req_o` stays high across the boundary, and `mem_we_o` drops on the same edge.
- Reset value of every output:
  - `cpu_stall_o` = `cpu_req_i & ~hit`, where hit is 0 because all lines are invalid;
  - `cpu_rdata_o` = 0;
  - all `mem_*` outputs = 0.
- Reset mid-operation: the FSM returns to IDLE asynchronously and `mem_req_o` drops immediately. The in-flight transaction is abandoned, and all valid/dirty bits are cleared.
- Back-to-back accesses to different lines need no bubble when both hit.

## Test plan
- Cold read miss:
  - stimulus: after reset, load 0x0000_0104; memory L = 10 returns a line whose word 1 = 32'hDEAD_BEEF;
  - required: stall high for 11 cycles, `mem_we_o` = 0, `mem_addr_o` = 0x100; stall falls with `cpu_rdata_o` = 32'hDEAD_BEEF.
- Write hit then read:
  - stimulus: store 32'h1234_5678 to 0x104, then load 0x104;
  - required: no stall on either access; the load returns 32'h1234_5678.
- Dirty conflict:
  - stimulus: load 0x0000_0304 (same index 8, tag 1);
  - required: a WRITEBACK to 0x100 whose `mem_wdata_o` word 1 = 32'h1234_5678, then a fetch from 0x300; stall high for 21 cycles.
- Clean conflict:
  - stimulus: load 0x104 again while the 0x300 line is clean;
  - required: no write-back; stall high for 11 cycles.
- Store miss:
  - stimulus: store 32'hA5A5_A5A5 to 0x0000_0008;
  - required: refill from 0x000, then the line at index 0 is dirty; a later conflicting access to 0x208 writes back a line whose word 2 = 32'hA5A5_A5A5.
- Reset during ALLOCATE:
  - stimulus: assert `start_i` = 0 at cycle 5 of a refill, then send a late `mem_ack_i` after release;
  - required: `mem_req_o` drops asynchronously; the late ack is ignored; the next load to 0x104 misses.
